// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Desc     : Moore FSM sequencing the multicycle MIPS datapath. Define
//            MEM_WAIT_EN to enable the mem_ready handshake and stall timeout.
// Revision : 1.0
// ============================================================================
module multicycle_control_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_R_EXEC   = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_I_EXEC   = 4'd11;
  localparam logic [3:0] S_I_WB     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;

  logic [3:0] state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic       illegal_q, illegal_d;
  logic       mem_err_q, mem_err_d;
  logic       w_ready;
  logic       w_timeout;

`ifdef MEM_WAIT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_mem_state;

  assign w_ready     = mem_ready;
  assign w_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                       (state_q == S_MEM_WR);
  // mem_ready on the last allowed cycle wins over the timeout.
  assign w_timeout   = w_mem_state && !mem_ready &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (w_mem_state && !mem_ready && !w_timeout && (state_d == state_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic             unused_mem_ready;
  logic [CNT_W-1:0] unused_timeout;

  assign w_ready          = 1'b1;
  assign w_timeout        = 1'b0;
  assign unused_mem_ready = mem_ready;
  assign unused_timeout   = CNT_W'(TIMEOUT - 1);
`endif

  assign opcode_d  = (state_q == S_DECODE) ? opcode : opcode_q;
  assign mem_err_d = w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        // A timed-out fetch restarts the fetch from the same PC.
        if (w_ready) begin
          state_d = S_DECODE;
        end else if (w_timeout) begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                          state_d = S_R_EXEC;
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_BEQ:                            state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (opcode_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (w_ready) begin
          state_d = S_MEM_WB;
        end else if (w_timeout) begin
          state_d = S_FETCH;
        end
      end
      S_MEM_WR: begin
        if (w_ready || w_timeout) begin
          state_d = S_FETCH;
        end
      end
      S_R_EXEC: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = w_ready;
        IRWrite = w_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (opcode_q)
          OP_ANDI: ALUOp = ALU_AND;
          OP_ORI:  ALUOp = ALU_OR;
          OP_SLTI: ALUOp = ALU_SLT;
          default: ALUOp = ALU_ADD;
        endcase
      end
      S_I_WB:  RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign illegal_op = illegal_q;
  assign mem_err    = mem_err_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// Directed testbench for multicycle_control_unit (TIMEOUT=4); expectations
// follow the MEM_WAIT_EN build selection.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h3f;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op, mem_err;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALUOp;
  logic [3:0] state;

  int checks = 0;
  int fails  = 0;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_F = 4'd1, ST_D = 4'd2, ST_MA = 4'd3;
  localparam logic [3:0] ST_MRD = 4'd4, ST_MWB = 4'd5, ST_MWR = 4'd6, ST_REX = 4'd7;
  localparam logic [3:0] ST_RWB = 4'd8, ST_BR = 4'd9, ST_J = 4'd10, ST_IEX = 4'd11;
  localparam logic [3:0] ST_IWB = 4'd12;

  // {illegal, mem_err, PCW, PCWC, IorD, MRd, MWr, MtoR, IRW, SrcA, RegW, RDst, PCSrc, SrcB, ALUOp}
  localparam logic [18:0] X_ZERO  = 19'b00_0000000000_00_00_000;
  localparam logic [18:0] X_FETCH = 19'b00_1001001000_00_01_000;
  localparam logic [18:0] X_FETW  = 19'b00_0001000000_00_01_000;
  localparam logic [18:0] X_DEC   = 19'b00_0000000000_00_11_000;
  localparam logic [18:0] X_MADDR = 19'b00_0000000100_00_10_000;
  localparam logic [18:0] X_MRD   = 19'b00_0011000000_00_00_000;
  localparam logic [18:0] X_MWB   = 19'b00_0000010010_00_00_000;
  localparam logic [18:0] X_MWR   = 19'b00_0010100000_00_00_000;
  localparam logic [18:0] X_REX   = 19'b00_0000000100_00_00_010;
  localparam logic [18:0] X_RWB   = 19'b00_0000000011_00_00_000;
  localparam logic [18:0] X_BR    = 19'b00_0100000100_01_00_001;
  localparam logic [18:0] X_JMP   = 19'b00_1000000000_10_00_000;
  localparam logic [18:0] X_IADD  = 19'b00_0000000100_00_10_000;
  localparam logic [18:0] X_IAND  = 19'b00_0000000100_00_10_100;
  localparam logic [18:0] X_IOR   = 19'b00_0000000100_00_10_101;
  localparam logic [18:0] X_ISLT  = 19'b00_0000000100_00_10_011;
  localparam logic [18:0] X_IWB   = 19'b00_0000000010_00_00_000;
  localparam logic [18:0] X_ILL   = 19'b10_0000000000_00_00_000;
  localparam logic [18:0] X_MERR  = 19'b01_0000000000_00_00_000;

  wire [18:0] obs = {illegal_op, mem_err, PCWrite, PCWriteCond, IorD, MemRead,
                     MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst,
                     PCSource, ALUSrcB, ALUOp};

  multicycle_control_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic cyc(input logic r, input logic [5:0] o);
    @(negedge clk);
    mem_ready = r;
    opcode    = o;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 6'h00);
      checks++;
      if (state !== ST_IDLE || obs !== X_ZERO) begin
        fails++;
        $display("FAIL reset_hold[%0d]: state=%0d obs=%b expected state=0 obs=%b", i, state, obs, X_ZERO);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== ST_IDLE || obs !== X_ZERO) begin
      fails++;
      $display("FAIL reset_release: state=%0d obs=%b expected state=0 obs=%b", state, obs, X_ZERO);
    end
  endtask

  task automatic test_rtype();
    logic [0:3]  rd = 4'b1111;
    logic [5:0]  op [4] = '{6'h3f, 6'h00, 6'h3f, 6'h3f};
    logic [3:0]  es [4] = '{ST_F, ST_D, ST_REX, ST_RWB};
    logic [18:0] ex [4] = '{X_FETCH, X_DEC, X_REX, X_RWB};
    for (int i = 0; i < 4; i++) begin
      cyc(rd[i], op[i]);
      checks++;
      if (state !== es[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL rtype[%0d]: state=%0d obs=%b expected state=%0d obs=%b", i, state, obs, es[i], ex[i]);
      end
    end
  endtask

  task automatic test_lw();
`ifdef MEM_WAIT_EN
    int          n = 8;
    logic [0:7]  rd = 8'b11100011;
    logic [5:0]  op [8] = '{6'h3f, 6'h23, 6'h2b, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f};
    logic [3:0]  es [8] = '{ST_F, ST_D, ST_MA, ST_MRD, ST_MRD, ST_MRD, ST_MRD, ST_MWB};
    logic [18:0] ex [8] = '{X_FETCH, X_DEC, X_MADDR, X_MRD, X_MRD, X_MRD, X_MRD, X_MWB};
`else
    int          n = 5;
    logic [0:7]  rd = 8'b00000000;
    logic [5:0]  op [8] = '{6'h3f, 6'h23, 6'h2b, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f};
    logic [3:0]  es [8] = '{ST_F, ST_D, ST_MA, ST_MRD, ST_MWB, ST_F, ST_F, ST_F};
    logic [18:0] ex [8] = '{X_FETCH, X_DEC, X_MADDR, X_MRD, X_MWB, X_FETCH, X_FETCH, X_FETCH};
`endif
    for (int i = 0; i < n; i++) begin
      cyc(rd[i], op[i]);
      checks++;
      if (state !== es[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL lw[%0d]: state=%0d obs=%b expected state=%0d obs=%b", i, state, obs, es[i], ex[i]);
      end
    end
  endtask

  task automatic test_itype();
    logic [5:0]  op [16] = '{6'h3f, 6'h0c, 6'h0d, 6'h3f, 6'h3f, 6'h0d, 6'h0c, 6'h3f,
                             6'h3f, 6'h08, 6'h0a, 6'h3f, 6'h3f, 6'h0a, 6'h08, 6'h3f};
    logic [3:0]  es [16] = '{ST_F, ST_D, ST_IEX, ST_IWB, ST_F, ST_D, ST_IEX, ST_IWB,
                             ST_F, ST_D, ST_IEX, ST_IWB, ST_F, ST_D, ST_IEX, ST_IWB};
    logic [18:0] ex [16] = '{X_FETCH, X_DEC, X_IAND, X_IWB, X_FETCH, X_DEC, X_IOR, X_IWB,
                             X_FETCH, X_DEC, X_IADD, X_IWB, X_FETCH, X_DEC, X_ISLT, X_IWB};
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, op[i]);
      checks++;
      if (state !== es[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL itype[%0d]: state=%0d obs=%b expected state=%0d obs=%b", i, state, obs, es[i], ex[i]);
      end
    end
  endtask

  task automatic test_sw_branch_jump();
    logic [5:0]  op [10] = '{6'h3f, 6'h2b, 6'h23, 6'h3f, 6'h3f, 6'h04, 6'h3f, 6'h3f, 6'h02, 6'h3f};
    logic [3:0]  es [10] = '{ST_F, ST_D, ST_MA, ST_MWR, ST_F, ST_D, ST_BR, ST_F, ST_D, ST_J};
    logic [18:0] ex [10] = '{X_FETCH, X_DEC, X_MADDR, X_MWR, X_FETCH, X_DEC, X_BR,
                             X_FETCH, X_DEC, X_JMP};
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, op[i]);
      checks++;
      if (state !== es[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL sw_br_j[%0d]: state=%0d obs=%b expected state=%0d obs=%b", i, state, obs, es[i], ex[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0]  op [5] = '{6'h3f, 6'h3f, 6'h3f, 6'h02, 6'h3f};
    logic [3:0]  es [5] = '{ST_F, ST_D, ST_F, ST_D, ST_J};
    logic [18:0] ex [5] = '{X_FETCH, X_DEC, X_FETCH | X_ILL, X_DEC, X_JMP};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, op[i]);
      checks++;
      if (state !== es[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL illegal[%0d]: state=%0d obs=%b expected state=%0d obs=%b", i, state, obs, es[i], ex[i]);
      end
    end
  endtask

  task automatic test_timeout();
`ifdef MEM_WAIT_EN
    int          n = 21;
    logic [0:20] rd = 21'b111000011100010000111;
    logic [5:0]  op [21] = '{6'h3f, 6'h2b, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f,
                             6'h3f, 6'h2b, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f,
                             6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h02, 6'h3f};
    logic [3:0]  es [21] = '{ST_F, ST_D, ST_MA, ST_MWR, ST_MWR, ST_MWR, ST_MWR,
                             ST_F, ST_D, ST_MA, ST_MWR, ST_MWR, ST_MWR, ST_MWR,
                             ST_F, ST_F, ST_F, ST_F, ST_F, ST_D, ST_J};
    logic [18:0] ex [21] = '{X_FETCH, X_DEC, X_MADDR, X_MWR, X_MWR, X_MWR, X_MWR,
                             X_FETCH | X_MERR, X_DEC, X_MADDR, X_MWR, X_MWR, X_MWR, X_MWR,
                             X_FETW, X_FETW, X_FETW, X_FETW, X_FETCH | X_MERR, X_DEC, X_JMP};
`else
    int          n = 7;
    logic [0:20] rd = 21'b0;
    logic [5:0]  op [21] = '{6'h3f, 6'h2b, 6'h3f, 6'h3f, 6'h3f, 6'h02, 6'h3f,
                             6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f,
                             6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f};
    logic [3:0]  es [21] = '{ST_F, ST_D, ST_MA, ST_MWR, ST_F, ST_D, ST_J,
                             ST_F, ST_F, ST_F, ST_F, ST_F, ST_F, ST_F,
                             ST_F, ST_F, ST_F, ST_F, ST_F, ST_F, ST_F};
    logic [18:0] ex [21] = '{X_FETCH, X_DEC, X_MADDR, X_MWR, X_FETCH, X_DEC, X_JMP,
                             X_FETCH, X_FETCH, X_FETCH, X_FETCH, X_FETCH, X_FETCH, X_FETCH,
                             X_FETCH, X_FETCH, X_FETCH, X_FETCH, X_FETCH, X_FETCH, X_FETCH};
`endif
    for (int i = 0; i < n; i++) begin
      cyc(rd[i], op[i]);
      checks++;
      if (state !== es[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL timeout[%0d]: state=%0d obs=%b expected state=%0d obs=%b", i, state, obs, es[i], ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [0:3]  rd = 4'b1110;
    logic [5:0]  op [4] = '{6'h3f, 6'h2b, 6'h3f, 6'h3f};
    logic [3:0]  es [4] = '{ST_F, ST_D, ST_MA, ST_MWR};
    logic [18:0] ex [4] = '{X_FETCH, X_DEC, X_MADDR, X_MWR};
    for (int i = 0; i < 4; i++) begin
      cyc(rd[i], op[i]);
      checks++;
      if (state !== es[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL reset_mid_pre[%0d]: state=%0d obs=%b expected state=%0d obs=%b", i, state, obs, es[i], ex[i]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== ST_IDLE || obs !== X_ZERO) begin
      fails++;
      $display("FAIL reset_mid_async: state=%0d obs=%b expected state=0 obs=%b", state, obs, X_ZERO);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== ST_IDLE || obs !== X_ZERO) begin
      fails++;
      $display("FAIL reset_mid_release: state=%0d obs=%b expected state=0 obs=%b", state, obs, X_ZERO);
    end
    cyc(1'b1, 6'h3f);
    checks++;
    if (state !== ST_F || obs !== X_FETCH) begin
      fails++;
      $display("FAIL reset_mid_fetch: state=%0d obs=%b expected state=1 obs=%b", state, obs, X_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_itype();
    test_sw_branch_jump();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

- Moore-style finite-state controller for the multicycle MIPS datapath.
- Replaces the single-cycle opcode decoder: it sequences each instruction over 3–5 cycles and drives the shared-memory, IR, PC and ALU-source selects every cycle.
- Adds a memory-ready handshake with a stall timeout, distinct ALU codes for logical immediates, and an illegal-opcode flag.

## Interface

Parameters:
- TIMEOUT, 16, max wait cycles for mem_ready in a memory state; legal range 2..255.
- CNT_W, $clog2(TIMEOUT+1), width of the stall counter (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction opcode; must be valid whenever state is DECODE.
- mem_ready  in  1  memory access complete this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls.
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target.
- ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- ALUOp  out  3  000 add, 001 sub, 010 funct, 011 slt, 100 and, 101 or.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- mem_err  out  1  one-cycle pulse on a stall timeout.
- state  out  4  current state code, for debug.

## Operation

States and codes:
- IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, I_EXEC 11, I_WB 12.
- Unused codes 13–15 recover to FETCH on the next edge.

Per-state outputs; anything not listed is 0:
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00. PCWrite and IRWrite equal mem_ready. Go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000. Next state by opcode:
  - 000000 → R_EXEC
  - 100011 / 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 / 001100 / 001101 / 001010 → I_EXEC
  - any other opcode → FETCH with illegal_op=1 for that cycle
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next is MEM_RD for lw, MEM_WR for sw. The opcode used here is latched at DECODE.
- MEM_RD: MemRead=1, IorD=1. Go to MEM_WB on mem_ready.
- MEM_WB: RegWrite=1, MemToReg=1, RegDst=0. Next is FETCH.
- MEM_WR: MemWrite=1, IorD=1. Go to FETCH on mem_ready.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next is R_WB.
- R_WB: RegWrite=1, RegDst=1, MemToReg=0. Next is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01. Next is FETCH.
- JUMP: PCWrite=1, PCSource=10. Next is FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10. ALUOp by opcode: addi 000, andi 100, ori 101, slti 011. Next is I_WB.
- I_WB: RegWrite=1, RegDst=0, MemToReg=0. Next is FETCH.

Opcode latch and stall counter:
- The opcode is latched into an internal 6-bit register on the DECODE edge. MEM_ADDR and I_EXEC use the latch, not the live input.
- Stall counter: increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0. It clears on any state change and on mem_ready=1.
- When the counter equals TIMEOUT-1 and mem_ready is still 0:
  - mem_err pulses for one cycle.
  - The FSM goes to FETCH, aborting the access with no PC, IR or register write.
  - A timeout in FETCH re-enters FETCH.
- mem_ready=1 on the timeout cycle wins: the access completes normally and mem_err stays 0.

## Timing

Reset:
- While rst_n=0, state=IDLE, the counter and opcode latch are 0, and every output is 0.
- Deassertion is synchronised internally by the first edge: the edge after rst_n rises moves IDLE→FETCH.
- Reset mid-instruction aborts immediately; no partial write completes after the asynchronous assert.

Cycles per instruction with zero wait:
- R-type 4, I-type 4, lw 5, sw 4, beq 3, j 3.
- Each wait cycle adds 1.

Output timing:
- All outputs are combinational from the state register.
- Exception: PCWrite and IRWrite in FETCH are also gated by mem_ready.
- illegal_op and mem_err are registered pulses, visible the cycle after detection.

## Configuration

MEM_WAIT_EN:
- Defined: the mem_ready handshake and stall counter are as above.
- Undefined:
  - mem_ready is ignored and treated as 1.
  - The counter logic is removed.
  - mem_err is tied to 0.
  - FETCH, MEM_RD and MEM_WR each last exactly one cycle.

## Test plan

- Reset, then R-type (000000), mem_ready=1: state sequence 0,1,2,7,8,1. RegWrite=1 and RegDst=1 only in R_WB. All outputs 0 while rst_n=0.
- lw (100011) with mem_ready low for 3 cycles in MEM_RD: FSM holds in MEM_RD 4 cycles. MemToReg=1 and RegWrite=1 for exactly one cycle in MEM_WB. Total 8 cycles.
- andi (001100), then ori (001101): ALUOp=100, then 101, in I_EXEC. The opcode input is changed after DECODE to prove the latch is used.
- Opcode 111111 at DECODE: illegal_op is a one-cycle pulse, the FSM returns to FETCH, and there are no RegWrite, MemWrite or PC writes.
- MEM_WAIT_EN defined, TIMEOUT=4, sw with mem_ready held 0:
  - After 4 cycles in MEM_WR, mem_err pulses and the FSM returns to FETCH.
  - Repeat with mem_ready=1 on the 4th cycle: normal completion and no mem_err.
- rst_n asserted mid-MEM_WR: MemWrite drops asynchronously, state=0. After release, FETCH follows on the next edge.
